// File: rtl/sim_run_sequencer.sv
// Run sequencer for the emulator harness: holds the DUT in reset, counts run
// cycles, and ends each run on success, max-cycle timeout or watchdog hang.
module sim_run_sequencer #(
  parameter int RESET_DELAY = 10,
  parameter int CNT_W       = 64,
  parameter int WDOG_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              verbose,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic [WDOG_W-1:0] wdog_limit,
  input  logic              dut_success,
  input  logic              dut_progress,
  output logic              dut_reset,
  output logic              printf_cond,
  output logic              running,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              finish
);

  localparam int RST_W = (RESET_DELAY < 2) ? 1 : $clog2(RESET_DELAY + 1);

  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;
  typedef enum logic [1:0] {ST_NONE, ST_PASS, ST_TIMEOUT, ST_HANG} status_t;

  state_t            state_q, state_d;
  logic              dutReset_q, dutReset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              finish_q, finish_d;
  status_t           status_q, status_d;
  logic [CNT_W-1:0]  cycleCount_q, cycleCount_d;
  logic [CNT_W-1:0]  maxLat_q, maxLat_d;
  logic [WDOG_W-1:0] wdogLim_q, wdogLim_d;
  logic [WDOG_W-1:0] wdogCnt_q, wdogCnt_d;
  logic [RST_W-1:0]  rstCnt_q, rstCnt_d;

  logic successHit, timeoutHit, hangHit;

  assign successHit = dut_success;
  assign timeoutHit = (cycleCount_q == maxLat_q);
  assign hangHit    = (wdogLim_q != '0) && (wdogCnt_q == wdogLim_q - WDOG_W'(1)) && !dut_progress;

  always_comb begin
    state_d      = state_q;
    dutReset_d   = dutReset_q;
    running_d    = running_q;
    done_d       = done_q;
    finish_d     = 1'b0;
    status_d     = status_q;
    cycleCount_d = cycleCount_q;
    maxLat_d     = maxLat_q;
    wdogLim_d    = wdogLim_q;
    wdogCnt_d    = wdogCnt_q;
    rstCnt_d     = rstCnt_q;

    case (state_q)
      IDLE, DONE: begin
        dutReset_d = 1'b1;
        running_d  = 1'b0;
        if (start) begin
          maxLat_d     = max_cycles;
          wdogLim_d    = wdog_limit;
          cycleCount_d = '0;
          status_d     = ST_NONE;
          rstCnt_d     = '0;
          wdogCnt_d    = '0;
          done_d       = 1'b0;
          state_d      = RST;
        end
      end
      RST: begin
        rstCnt_d = rstCnt_q + RST_W'(1);
        if (rstCnt_q == RST_W'(RESET_DELAY - 1)) begin
          state_d      = RUN;
          dutReset_d   = 1'b0;
          running_d    = 1'b1;
          cycleCount_d = '0;
          wdogCnt_d    = '0;
        end
      end
      RUN: begin
        wdogCnt_d = dut_progress ? '0 : wdogCnt_q + WDOG_W'(1);
        // Exit priority is success, then timeout, then hang; the count freezes on exit.
        if (successHit || timeoutHit || hangHit) begin
          state_d    = DONE;
          dutReset_d = 1'b1;
          running_d  = 1'b0;
          done_d     = 1'b1;
          finish_d   = 1'b1;
          if (successHit)      status_d = ST_PASS;
          else if (timeoutHit) status_d = ST_TIMEOUT;
          else                 status_d = ST_HANG;
        end else begin
          cycleCount_d = cycleCount_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      dutReset_q   <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      finish_q     <= 1'b0;
      status_q     <= ST_NONE;
      cycleCount_q <= '0;
      maxLat_q     <= '0;
      wdogLim_q    <= '0;
      wdogCnt_q    <= '0;
      rstCnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      dutReset_q   <= dutReset_d;
      running_q    <= running_d;
      done_q       <= done_d;
      finish_q     <= finish_d;
      status_q     <= status_d;
      cycleCount_q <= cycleCount_d;
      maxLat_q     <= maxLat_d;
      wdogLim_q    <= wdogLim_d;
      wdogCnt_q    <= wdogCnt_d;
      rstCnt_q     <= rstCnt_d;
    end
  end

  assign dut_reset   = dutReset_q;
  assign printf_cond = verbose && !dutReset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign finish      = finish_q;
  assign status      = status_q;
  assign cycle_count = cycleCount_q;

endmodule
